// File: rtl/motor_cmd_ramp.sv
// motor_cmd_ramp: command front-end for the dc_motor PWM block.
// Ramps the 3-bit psw code one duty level per STEP_TICKS.
// Holds OFF for DWELL_TICKS before any direction reversal.
// Drops straight to OFF while estop is asserted.
module motor_cmd_ramp #(
  parameter int unsigned STEP_TICKS  = 1000,
  parameter int unsigned DWELL_TICKS = 5000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_level,
  input  logic       cmd_dir,
  input  logic       estop,
  output logic [2:0] psw,
  output logic       at_target
);

  typedef enum logic [2:0] {HOLD, RAMP_UP, RAMP_DOWN, DWELL, ESTOP} state_t;

  localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_TICKS - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 1);

  state_t           state, state_n, want;
  logic [1:0]       cur_lvl, cur_lvl_n, tgt_lvl, tgt_lvl_n, step_lvl;
  logic             cur_dir, cur_dir_n, tgt_dir, tgt_dir_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic             accept;

  // Where the motor must head next given the present level/direction and target.
  function automatic state_t decide(input logic [1:0] c_lvl, input logic c_dir,
                                    input logic [1:0] t_lvl, input logic t_dir);
    state_t s;
    if (t_lvl != 2'd0 && t_dir != c_dir) s = (c_lvl != 2'd0) ? RAMP_DOWN : DWELL;
    else if (t_lvl > c_lvl)              s = RAMP_UP;
    else if (t_lvl < c_lvl)              s = RAMP_DOWN;
    else                                 s = HOLD;
    return s;
  endfunction

  // Level/direction to dc_motor code; 111 is unreachable since reverse uses L-1.
  function automatic logic [2:0] encode(input logic [1:0] lvl, input logic dir);
    logic [2:0] code;
    if (lvl == 2'd0) code = 3'b000;
    else if (!dir)   code = {1'b0, lvl};
    else             code = {1'b1, lvl - 2'd1};
    return code;
  endfunction

  assign cmd_ready = rst_n & ~estop & (state != ESTOP);
  assign accept    = cmd_valid & cmd_ready;

  // Next-state, target load, ramp stepping and dwell timing.
  always_comb begin
    state_n   = state;
    cur_lvl_n = cur_lvl;
    cur_dir_n = cur_dir;
    tgt_lvl_n = tgt_lvl;
    tgt_dir_n = tgt_dir;
    timer_n   = timer;
    want      = HOLD;
    step_lvl  = cur_lvl;
    if (estop) begin
      state_n   = ESTOP;
      cur_lvl_n = 2'd0;
      timer_n   = '0;
    end else if (state == ESTOP) begin
      // Release: dwell at OFF with a zero target, ending in HOLD.
      tgt_lvl_n = 2'd0;
      timer_n   = '0;
      state_n   = DWELL;
    end else begin
      if (accept) begin
        tgt_lvl_n = cmd_level;
        tgt_dir_n = cmd_dir;
      end
      want = decide(cur_lvl, cur_dir, tgt_lvl_n, tgt_dir_n);
      if (state == DWELL) begin
        if (accept && want != DWELL) begin
          state_n = want;
          timer_n = '0;
        end else if (timer == DWELL_LAST) begin
          timer_n = '0;
          if (tgt_lvl_n == 2'd0) begin
            state_n = HOLD;
          end else begin
            cur_dir_n = tgt_dir_n;
            state_n   = RAMP_UP;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end else begin
        state_n = want;
        if (want == RAMP_UP || want == RAMP_DOWN) begin
          if (state == HOLD) begin
            timer_n = '0;
          end else if (timer == STEP_LAST) begin
            // Step first, then re-decide from the new level in the same cycle.
            step_lvl  = (want == RAMP_UP) ? cur_lvl + 2'd1 : cur_lvl - 2'd1;
            cur_lvl_n = step_lvl;
            timer_n   = '0;
            state_n   = decide(step_lvl, cur_dir, tgt_lvl_n, tgt_dir_n);
          end else begin
            timer_n = timer + 1'b1;
          end
        end else if (want == DWELL) begin
          timer_n = '0;
        end
      end
    end
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= HOLD;
      cur_lvl   <= 2'd0;
      cur_dir   <= 1'b0;
      tgt_lvl   <= 2'd0;
      tgt_dir   <= 1'b0;
      timer     <= '0;
      psw       <= 3'b000;
      at_target <= 1'b0;
    end else begin
      state     <= state_n;
      cur_lvl   <= cur_lvl_n;
      cur_dir   <= cur_dir_n;
      tgt_lvl   <= tgt_lvl_n;
      tgt_dir   <= tgt_dir_n;
      timer     <= timer_n;
      psw       <= encode(cur_lvl_n, cur_dir_n);
      at_target <= (state_n == HOLD);
    end
  end

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Bench for motor_cmd_ramp with STEP_TICKS=4, DWELL_TICKS=8.
module tb_motor_cmd_ramp;

  localparam int STEP  = 4;
  localparam int DWELL = 8;
  localparam int MI = 0, MM = 1, MD = 2, MS = 3;  // idle, moving, dwelling, stopped

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_level = 2'd0;
  logic       cmd_dir = 1'b0;
  logic       estop = 1'b0;
  logic [2:0] psw;
  logic       at_target;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: signed-free speed/direction plus a countdown to the next event.
  int   m_s = 0, m_d = 0, m_tl = 0, m_td = 0, m_mode = MI, m_rem = 0;
  bit   m_inrst = 1'b1;
  logic exp_ready, obs_ready;

  motor_cmd_ramp #(.STEP_TICKS(STEP), .DWELL_TICKS(DWELL), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_level(cmd_level), .cmd_dir(cmd_dir), .estop(estop),
    .psw(psw), .at_target(at_target)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1);
  end

  function automatic int m_want();
    if (m_tl > 0 && m_td != m_d) return (m_s > 0) ? MM : MD;
    return (m_tl != m_s) ? MM : MI;
  endfunction

  function automatic logic [2:0] m_psw();
    if (m_s == 0) return 3'd0;
    return (m_d == 0) ? 3'(m_s) : 3'(3 + m_s);
  endfunction

  function automatic logic m_at();
    return (!m_inrst && m_mode == MI);
  endfunction

  function automatic void m_edge(input bit acc, input int lvl, input int dir, input bit e, input bit r);
    int w;
    m_inrst = !r;
    if (!r) begin
      m_s = 0; m_d = 0; m_tl = 0; m_td = 0; m_mode = MI; m_rem = 0;
      return;
    end
    if (e) begin m_s = 0; m_mode = MS; return; end
    if (m_mode == MS) begin m_tl = 0; m_mode = MD; m_rem = DWELL; return; end
    if (acc) begin m_tl = lvl; m_td = dir; end
    w = m_want();
    if (m_mode == MD) begin
      if (acc && w != MD) begin
        m_mode = w;
        m_rem  = (w == MM) ? STEP : 0;
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_tl == 0) m_mode = MI;
          else begin m_d = m_td; m_mode = MM; m_rem = STEP; end
        end
      end
    end else if (w == MM) begin
      if (m_mode == MI) begin
        m_mode = MM; m_rem = STEP;
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_s += ((m_tl > 0 && m_td != m_d) || m_tl < m_s) ? -1 : 1;
          m_rem = STEP;
          w = m_want();
          m_mode = w;
          if (w == MD) m_rem = DWELL;
        end
      end
    end else begin
      m_mode = w;
      if (w == MD) m_rem = DWELL;
    end
  endfunction

  // Drive one cycle of inputs, sample cmd_ready before the edge, advance model.
  task automatic tick(input logic v, input logic [1:0] l, input logic d, input logic e, input logic r);
    cmd_valid = v; cmd_level = l; cmd_dir = d; estop = e; rst_n = r;
    #1;
    obs_ready = cmd_ready;
    exp_ready = r && !e && (m_mode != MS);
    @(posedge clk);
    m_edge(v && exp_ready, int'(l), int'(d), e, r);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
      n_checks++; if (psw !== 3'b000) begin n_fail++; $display("FAIL reset_psw got %b want 000", psw); end
      n_checks++; if (at_target !== 1'b0) begin n_fail++; $display("FAIL reset_at got %b want 0", at_target); end
      n_checks++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", obs_ready); end
    end
    tick(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (at_target !== 1'b1) begin n_fail++; $display("FAIL release_at got %b want 1", at_target); end
    n_checks++; if (psw !== 3'b000) begin n_fail++; $display("FAIL release_psw got %b want 000", psw); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_ramp_up();
    logic [2:0] ep;
    for (int e = 0; e <= 16; e++) begin
      tick(e == 0, 2'd3, 1'b0, 1'b0, 1'b1);
      ep = (e >= 12) ? 3'd3 : 3'(e / 4);
      n_checks++; if (psw !== ep) begin n_fail++; $display("FAIL ramp_up_psw e=%0d got %b want %b", e, psw, ep); end
      n_checks++; if (at_target !== (e >= 12)) begin n_fail++; $display("FAIL ramp_up_at e=%0d got %b want %b", e, at_target, e >= 12); end
      n_checks++; if (psw !== m_psw()) begin n_fail++; $display("FAIL ramp_up_model e=%0d got %b want %b", e, psw, m_psw()); end
    end
  endtask

  task automatic test_reversal();
    logic [2:0] ep;
    for (int e = 0; e <= 32; e++) begin
      tick(e == 0, 2'd2, 1'b1, 1'b0, 1'b1);
      if (e < 4)       ep = 3'b011;
      else if (e < 8)  ep = 3'b010;
      else if (e < 12) ep = 3'b001;
      else if (e < 24) ep = 3'b000;
      else if (e < 28) ep = 3'b100;
      else             ep = 3'b101;
      n_checks++; if (psw !== ep) begin n_fail++; $display("FAIL reversal_psw e=%0d got %b want %b", e, psw, ep); end
      n_checks++; if (at_target !== (e >= 28)) begin n_fail++; $display("FAIL reversal_at e=%0d got %b want %b", e, at_target, e >= 28); end
      n_checks++; if (psw !== m_psw()) begin n_fail++; $display("FAIL reversal_model e=%0d got %b want %b", e, psw, m_psw()); end
    end
  endtask

  task automatic test_override();
    logic [2:0] ep;
    logic       et;
    tick(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int e = 0; e <= 16; e++) begin
      if (e == 6)       tick(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
      else if (e == 10) tick(1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
      else              tick(e == 0, 2'd3, 1'b0, 1'b0, 1'b1);
      ep = (e >= 4 && e < 14) ? 3'b001 : 3'b000;
      et = (e >= 6 && e < 10) || (e >= 14);
      n_checks++; if (psw !== ep) begin n_fail++; $display("FAIL override_psw e=%0d got %b want %b", e, psw, ep); end
      n_checks++; if (at_target !== et) begin n_fail++; $display("FAIL override_at e=%0d got %b want %b", e, at_target, et); end
      n_checks++; if (at_target !== m_at()) begin n_fail++; $display("FAIL override_model e=%0d got %b want %b", e, at_target, m_at()); end
    end
  endtask

  task automatic test_estop();
    logic [2:0] ep;
    logic       er;
    tick(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int e = 0; e <= 32; e++) begin
      if (e >= 10 && e < 20) tick(1'b1, 2'd2, 1'b1, 1'b1, 1'b1);
      else                   tick(e == 0, 2'd3, 1'b0, 1'b0, 1'b1);
      if (e < 4)       ep = 3'b000;
      else if (e < 8)  ep = 3'b001;
      else if (e < 10) ep = 3'b010;
      else             ep = 3'b000;
      er = !(e >= 10 && e <= 20);
      n_checks++; if (psw !== ep) begin n_fail++; $display("FAIL estop_psw e=%0d got %b want %b", e, psw, ep); end
      n_checks++; if (at_target !== (e >= 28)) begin n_fail++; $display("FAIL estop_at e=%0d got %b want %b", e, at_target, e >= 28); end
      n_checks++; if (obs_ready !== er) begin n_fail++; $display("FAIL estop_ready e=%0d got %b want %b", e, obs_ready, er); end
      n_checks++; if (psw !== m_psw()) begin n_fail++; $display("FAIL estop_model e=%0d got %b want %b", e, psw, m_psw()); end
    end
  endtask

  task automatic test_rev_from_reset();
    logic [2:0] ep;
    tick(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int e = 0; e <= 16; e++) begin
      tick(e == 0, 2'd1, 1'b1, 1'b0, 1'b1);
      ep = (e >= 12) ? 3'b100 : 3'b000;
      n_checks++; if (psw !== ep) begin n_fail++; $display("FAIL rev_reset_psw e=%0d got %b want %b", e, psw, ep); end
      n_checks++; if (at_target !== (e >= 12)) begin n_fail++; $display("FAIL rev_reset_at e=%0d got %b want %b", e, at_target, e >= 12); end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] lv [2] = '{2'd1, 2'd3};
    logic       dr [2] = '{1'b1, 1'b0};
    int         rn [2] = '{3, 6};
    for (int s = 0; s < 2; s++) begin
      for (int e = 0; e < rn[s]; e++) tick(e == 0, lv[s], dr[s], 1'b0, 1'b1);
      tick(1'b1, lv[s], dr[s], 1'b0, 1'b0);
      n_checks++; if (psw !== 3'b000) begin n_fail++; $display("FAIL mid_reset_psw s=%0d got %b want 000", s, psw); end
      n_checks++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready s=%0d got %b want 0", s, obs_ready); end
      n_checks++; if (at_target !== 1'b0) begin n_fail++; $display("FAIL mid_reset_at s=%0d got %b want 0", s, at_target); end
      tick(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
      n_checks++; if (at_target !== 1'b1) begin n_fail++; $display("FAIL mid_release_at s=%0d got %b want 1", s, at_target); end
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready s=%0d got %b want 1", s, cmd_ready); end
      n_checks++; if (psw !== 3'b000) begin n_fail++; $display("FAIL mid_release_psw s=%0d got %b want 000", s, psw); end
    end
  endtask

  task automatic test_random();
    int   est_cnt = 0;
    logic v, d, e, r;
    logic [1:0] l;
    for (int i = 0; i < 3000; i++) begin
      if (est_cnt == 0 && $urandom_range(0, 199) == 0) est_cnt = $urandom_range(1, 12);
      e = (est_cnt > 0);
      if (est_cnt > 0) est_cnt--;
      v = ($urandom_range(0, 99) < 35);
      l = 2'($urandom_range(0, 3));
      d = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 499) != 0);
      tick(v, l, d, e, r);
      n_checks++; if (psw !== m_psw()) begin n_fail++; $display("FAIL rand_psw i=%0d got %b want %b", i, psw, m_psw()); end
      n_checks++; if (at_target !== m_at()) begin n_fail++; $display("FAIL rand_at i=%0d got %b want %b", i, at_target, m_at()); end
      n_checks++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready i=%0d got %b want %b", i, obs_ready, exp_ready); end
      n_checks++; if (psw === 3'b111) begin n_fail++; $display("FAIL rand_no111 i=%0d got %b want not 111", i, psw); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_reversal();
    test_override();
    test_estop();
    test_rev_from_reset();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
